// File: rtl/restoring_div4b_if.sv
// rtl/restoring_div4b_if.sv - start/busy/done handshake and operand/result bundle for the divider
interface restoring_div4b_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_div4b.sv
// rtl/restoring_div4b.sv - sequential unsigned restoring divider, one trial subtraction per clock
module restoring_div4b #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  restoring_div4b_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    // Shift {R,Q} left, then trial-subtract D; the extra top bit of diff is the borrow.
    r_sh   = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
    q_sh   = q_q << 1;
    diff   = {1'b0, r_sh} - {2'b00, d_q};
    borrow = diff[WIDTH+1];
    r_next = borrow ? r_sh : diff[WIDTH:0];
    q_next = q_sh | {{(WIDTH-1){1'b0}}, ~borrow};

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (bus.start) begin
          d_d   = bus.divisor;
          dbz_d = 1'b0;
          if (bus.divisor != '0) begin
            q_d     = bus.dividend;
            r_d     = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        q_d   = q_next;
        r_d   = r_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quot_d  = q_next;
          rem_d   = r_next[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_div4b.sv
// tb/tb_restoring_div4b.sv - scoreboard bench for restoring_div4b
module tb_restoring_div4b;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic done_prev = 1'b0;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];

  restoring_div4b_if #(.WIDTH(4)) bus ();

  restoring_div4b #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 4'hF;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("busy_and_done", bus.busy & bus.done, 0);
      check("done_twice", done_prev & bus.done, 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", bus.done, 0);
        end else begin
          e = sb.pop_front();
          check("quotient", bus.quotient, e.q);
          check("remainder", bus.remainder, e.r);
          check("div_by_zero", bus.div_by_zero, e.dbz);
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    @(posedge clk) #1;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    sb.push_back(model(a, b));
    @(posedge clk) #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check(tag, bus.done, 1);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b);
    issue(a, b);
    wait_done("done_seen");
  endtask

  initial begin
    int t0;
    int t1;
    int nd;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    mon_en = 1'b1;

    // 13/3: busy for exactly 4 cycles, then a single done cycle
    issue(4'd13, 4'd3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("lat_busy", bus.busy, 1);
      check("lat_done_low", bus.done, 0);
    end
    @(negedge clk);
    check("lat_busy_end", bus.busy, 0);
    check("lat_done", bus.done, 1);

    run_op(4'd15, 4'd1);
    run_op(4'd5, 4'd9);
    run_op(4'd0, 4'd7);

    // divide by zero completes the cycle after the start edge without iterating
    issue(4'd7, 4'd0);
    @(negedge clk);
    check("dbz_done", bus.done, 1);
    check("dbz_busy", bus.busy, 0);

    // start during RUN is ignored
    @(posedge clk) #1;
    bus.start = 1'b1;
    bus.dividend = 4'd12;
    bus.divisor = 4'd5;
    sb.push_back(model(4'd12, 4'd5));
    @(posedge clk) #1;
    bus.start = 1'b0;
    @(posedge clk) #1;
    bus.start = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor = 4'd2;
    @(posedge clk) #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("ign_done_early", bus.done, 0);
    @(negedge clk);
    check("ign_done_early2", bus.done, 0);
    @(negedge clk);
    check("ign_done", bus.done, 1);

    // reset mid-operation abandons the result
    @(posedge clk) #1;
    bus.start = 1'b1;
    bus.dividend = 4'd14;
    bus.divisor = 4'd4;
    @(posedge clk) #1;
    bus.start = 1'b0;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_quotient", bus.quotient, 0);
    check("mid_rst_remainder", bus.remainder, 0);
    check("mid_rst_dbz", bus.div_by_zero, 0);
    repeat (6) begin
      @(negedge clk);
      check("mid_rst_no_done", bus.done, 0);
    end
    run_op(4'd9, 4'd2);

    // start held high: second operation accepted at the DONE edge
    @(posedge clk) #1;
    bus.start = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor = 4'd4;
    sb.push_back(model(4'd9, 4'd4));
    @(posedge clk) #1;
    bus.dividend = 4'd8;
    bus.divisor = 4'd3;
    sb.push_back(model(4'd8, 4'd3));
    t0 = 0;
    t1 = 0;
    nd = 0;
    for (int i = 0; i < 30 && nd < 2; i++) begin
      @(negedge clk);
      if (bus.done) begin
        nd = nd + 1;
        if (nd == 1) begin
          t0 = cyc;
          @(posedge clk) #1;
          bus.start = 1'b0;
        end else begin
          t1 = cyc;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_count", nd, 2);
    check("b2b_spacing", t1 - t0, 5);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b));
      end
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
